// File: rtl/qed_inst_constraint_mon_pkg.sv
// Package qed_inst_pkg: opcode, funct3 and funct7 constants, the canonical NOP word, the
// instruction class enum and the small legality helpers used by the single-lane decoder.
package qed_inst_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_RW    = 7'b0111011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_IW    = 7'b0011011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_D   = 3'b011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [2:0] {
        CLS_R       = 3'd0,
        CLS_I       = 3'd1,
        CLS_LS      = 3'd2,
        CLS_NOP     = 3'd3,
        CLS_ILLEGAL = 3'd4
    } inst_class_e;

    // True when a register index lies inside the QED partition [0, limit).
    function automatic logic reg_in_range(input logic [4:0] r, input int unsigned limit);
        return ({1'b0, r} < 6'(limit));
    endfunction

    // 64-bit ALU and M-extension encodings of opcode 0110011.
    function automatic logic r_legal(input logic [6:0] f7, input logic [2:0] f3);
        logic ok;
        case (f7)
            F7_BASE: ok = 1'b1;
            F7_MEXT: ok = 1'b1;
            F7_ALT:  ok = (f3 == F3_ADD) || (f3 == F3_SR);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // 32-bit W forms of opcode 0111011 (ADDW/SUBW/SLLW/SRLW/SRAW and MULW/DIVW/DIVUW/REMW/REMUW).
    function automatic logic rw_legal(input logic [6:0] f7, input logic [2:0] f3);
        logic ok;
        case (f7)
            F7_BASE: ok = (f3 == F3_ADD) || (f3 == F3_SLL) || (f3 == F3_SR);
            F7_ALT:  ok = (f3 == F3_ADD) || (f3 == F3_SR);
            F7_MEXT: ok = (f3 == F3_ADD) || f3[2];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Immediate ALU ops except the shifts (funct3 001/101).
    function automatic logic i_legal(input logic [2:0] f3);
        return (f3 != F3_SLL) && (f3 != F3_SR);
    endfunction

endpackage

// File: rtl/qed_inst_constraint_mon_if.sv
// Fetch-side bundle of the QED constraint monitor: per-lane valid bits, the packed
// instruction words, and the per-lane verdict returned by the monitor.
interface qed_inst_constraint_mon_if #(
    parameter int unsigned LANES = 2
) ();
    logic [LANES-1:0]    inst_valid;
    logic [32*LANES-1:0] inst;
    logic [LANES-1:0]    lane_ok;

    modport master (
        output inst_valid,
        output inst,
        input  lane_ok
    );

    modport slave (
        input  inst_valid,
        input  inst,
        output lane_ok
    );
endinterface

// File: rtl/qed_inst_decode.sv
// Single-lane combinational classifier: maps one instruction word onto its QED class and
// reports whether it belongs to the allowed subset under the register-partition limit.
module qed_inst_decode
    import qed_inst_pkg::*;
#(
    parameter int unsigned REG_LIMIT = 16,
    parameter bit          ALLOW_DW  = 1'b1
) (
    input  logic [31:0] inst,
    output inst_class_e inst_class,
    output logic        allowed
);

    logic [6:0]  opcode_s;
    logic [4:0]  rd_s;
    logic [2:0]  f3_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [6:0]  f7_s;
    logic        rd_ok_s;
    logic        rs1_ok_s;
    logic        rs2_ok_s;
    logic        ls_width_ok_s;
    logic        ls_base_ok_s;
    inst_class_e cls_s;

    assign opcode_s = inst[6:0];
    assign rd_s     = inst[11:7];
    assign f3_s     = inst[14:12];
    assign rs1_s    = inst[19:15];
    assign rs2_s    = inst[24:20];
    assign f7_s     = inst[31:25];

    assign rd_ok_s  = reg_in_range(rd_s, REG_LIMIT);
    assign rs1_ok_s = reg_in_range(rs1_s, REG_LIMIT);
    assign rs2_ok_s = reg_in_range(rs2_s, REG_LIMIT);

    // Loads/stores are restricted to x0-based addressing with a small non-negative offset.
    assign ls_width_ok_s = (f3_s == F3_W) || (ALLOW_DW && (f3_s == F3_D));
    assign ls_base_ok_s  = (rs1_s == 5'd0) && (inst[31:30] == 2'b00) && ls_width_ok_s;

    // Map the word onto its class; anything outside the subset is illegal.
    always_comb begin
        cls_s = CLS_ILLEGAL;
        if (inst == NOP_WORD) begin
            cls_s = CLS_NOP;
        end else begin
            case (opcode_s)
                OP_R: begin
                    if (r_legal(f7_s, f3_s) && rd_ok_s && rs1_ok_s && rs2_ok_s) cls_s = CLS_R;
                    else cls_s = CLS_ILLEGAL;
                end
                OP_RW: begin
                    if (rw_legal(f7_s, f3_s) && rd_ok_s && rs1_ok_s && rs2_ok_s) cls_s = CLS_R;
                    else cls_s = CLS_ILLEGAL;
                end
                OP_I: begin
                    if (i_legal(f3_s) && rd_ok_s && rs1_ok_s) cls_s = CLS_I;
                    else cls_s = CLS_ILLEGAL;
                end
                OP_IW: begin
                    if ((f3_s == F3_ADD) && rd_ok_s && rs1_ok_s) cls_s = CLS_I;
                    else cls_s = CLS_ILLEGAL;
                end
                OP_LOAD: begin
                    if (ls_base_ok_s && rd_ok_s) cls_s = CLS_LS;
                    else cls_s = CLS_ILLEGAL;
                end
                OP_STORE: begin
                    if (ls_base_ok_s && rs2_ok_s) cls_s = CLS_LS;
                    else cls_s = CLS_ILLEGAL;
                end
                default: cls_s = CLS_ILLEGAL;
            endcase
        end
    end

    assign inst_class = cls_s;
    assign allowed    = (cls_s != CLS_ILLEGAL);

endmodule

// File: rtl/qed_inst_constraint_mon.sv
// Multi-lane QED fetch constraint monitor: per-lane legality verdicts, sticky violation with
// first-offender capture, saturating accepted-instruction count and an idle-run watchdog.
// Optional build macro QED_INST_ASSUME_EN turns each lane's legality into a formal assumption.
module qed_inst_constraint_mon
    import qed_inst_pkg::*;
#(
    parameter int unsigned LANES       = 2,
    parameter int unsigned REG_LIMIT   = 16,
    parameter bit          ALLOW_DW    = 1'b1,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MAX_NOP_RUN = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    qed_inst_constraint_mon_if.slave    fetch,
    output logic                        violation,
    output logic [31:0]                 viol_inst,
    output logic [2:0]                  viol_lane,
    output logic [CNT_W-1:0]            acc_cnt,
    output logic                        nop_run_hit
);

    localparam int unsigned IDLE_W   = $clog2(MAX_NOP_RUN + 1);
    localparam int unsigned SUM_W    = CNT_W + 4;
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(MAX_NOP_RUN);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    inst_class_e        lane_cls_s [LANES];
    logic [LANES-1:0]   lane_allowed_s;
    logic [LANES-1:0]   is_nop_s;
    logic [LANES-1:0]   bad_s;
    logic               any_bad_s;
    logic               idle_s;
    logic [3:0]         pop_s;
    logic [2:0]         first_lane_s;
    logic [31:0]        first_inst_s;
    logic [SUM_W-1:0]   sum_s;
    logic [CNT_W-1:0]   acc_next_s;
    logic [IDLE_W-1:0]  idle_next_s;

    logic               violation_r;
    logic [31:0]        viol_inst_r;
    logic [2:0]         viol_lane_r;
    logic [CNT_W-1:0]   acc_cnt_r;
    logic               nop_run_hit_r;
    logic [IDLE_W-1:0]  idle_cnt_r;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        qed_inst_decode #(
            .REG_LIMIT (REG_LIMIT),
            .ALLOW_DW  (ALLOW_DW)
        ) u_dec (
            .inst       (fetch.inst[32*g +: 32]),
            .inst_class (lane_cls_s[g]),
            .allowed    (lane_allowed_s[g])
        );
        assign is_nop_s[g] = (lane_cls_s[g] == CLS_NOP);
    end

    assign fetch.lane_ok = fetch.inst_valid & lane_allowed_s;
    assign bad_s         = fetch.inst_valid & ~lane_allowed_s;
    assign any_bad_s     = |bad_s;
    assign idle_s        = &(~fetch.inst_valid | is_nop_s);

    // Count accepted lanes and pick the lowest-index offender (scan high to low, last hit wins).
    always_comb begin
        pop_s        = 4'd0;
        first_lane_s = 3'd0;
        first_inst_s = 32'd0;
        for (int i = LANES - 1; i >= 0; i--) begin
            pop_s = pop_s + {3'b000, fetch.lane_ok[i]};
            if (bad_s[i]) begin
                first_lane_s = 3'(i);
                first_inst_s = fetch.inst[32*i +: 32];
            end else begin
                first_lane_s = first_lane_s;
                first_inst_s = first_inst_s;
            end
        end
    end

    // Saturating accumulate: a partial add that would overflow clamps to all-ones.
    always_comb begin
        sum_s = SUM_W'(acc_cnt_r) + SUM_W'(pop_s);
        if (sum_s > SUM_W'(CNT_MAX)) begin
            acc_next_s = CNT_MAX;
        end else begin
            acc_next_s = sum_s[CNT_W-1:0];
        end
    end

    // Idle-run counter: climbs on idle cycles up to the limit, drops to zero on real work.
    always_comb begin
        if (!idle_s) begin
            idle_next_s = {IDLE_W{1'b0}};
        end else if (idle_cnt_r == IDLE_MAX) begin
            idle_next_s = IDLE_MAX;
        end else begin
            idle_next_s = idle_cnt_r + {{(IDLE_W-1){1'b0}}, 1'b1};
        end
    end

    // Sticky status, first-offender capture, counters; reset and clear override everything.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            violation_r   <= 1'b0;
            viol_inst_r   <= 32'd0;
            viol_lane_r   <= 3'd0;
            acc_cnt_r     <= {CNT_W{1'b0}};
            nop_run_hit_r <= 1'b0;
            idle_cnt_r    <= {IDLE_W{1'b0}};
        end else begin
            if (any_bad_s) begin
                violation_r <= 1'b1;
                if (!violation_r) begin
                    viol_inst_r <= first_inst_s;
                    viol_lane_r <= first_lane_s;
                end
            end
            acc_cnt_r  <= acc_next_s;
            idle_cnt_r <= idle_next_s;
            if (idle_s && (idle_next_s == IDLE_MAX)) begin
                nop_run_hit_r <= 1'b1;
            end
        end
    end

    assign violation   = violation_r;
    assign viol_inst   = viol_inst_r;
    assign viol_lane   = viol_lane_r;
    assign acc_cnt     = acc_cnt_r;
    assign nop_run_hit = nop_run_hit_r;

`ifdef QED_INST_ASSUME_EN
    for (genvar a = 0; a < LANES; a++) begin : g_assume
        lane_legal_a: assume property (@(posedge clk) !fetch.inst_valid[a] || fetch.lane_ok[a]);
    end
`else
    // Pure monitor build: illegal fetches are reported through violation only.
`endif

endmodule

// File: tb/tb_qed_inst_constraint_mon.sv
// Self-checking bench for qed_inst_constraint_mon. Two instances with different parameter sets
// are driven from the same lanes; a behavioural model tracks both.
module tb_qed_inst_constraint_mon;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] ADD  = 32'h0031_00B3;
    localparam logic [31:0] ADD20 = 32'h0010_8A33;
    localparam logic [31:0] SLLI = 32'h0010_1093;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic clear;

    qed_inst_constraint_mon_if #(.LANES(2)) bus_a ();
    qed_inst_constraint_mon_if #(.LANES(3)) bus_b ();

    logic        viol_a, viol_b, hit_a, hit_b;
    logic [31:0] vinst_a, vinst_b;
    logic [2:0]  vlane_a, vlane_b;
    logic [15:0] acc_a;
    logic [1:0]  acc_b;

    qed_inst_constraint_mon #(
        .LANES(2), .REG_LIMIT(16), .ALLOW_DW(1'b1), .CNT_W(16), .MAX_NOP_RUN(4)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .fetch(bus_a),
        .violation(viol_a), .viol_inst(vinst_a), .viol_lane(vlane_a),
        .acc_cnt(acc_a), .nop_run_hit(hit_a)
    );

    qed_inst_constraint_mon #(
        .LANES(3), .REG_LIMIT(8), .ALLOW_DW(1'b0), .CNT_W(2), .MAX_NOP_RUN(3)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .fetch(bus_b),
        .violation(viol_b), .viol_inst(vinst_b), .viol_lane(vlane_b),
        .acc_cnt(acc_b), .nop_run_hit(hit_b)
    );

    int checks = 0;
    int errors = 0;

    // Model parameters per instance
    function automatic int p_lanes(int d); return (d == 0) ? 2 : 3; endfunction
    function automatic int p_rl(int d);    return (d == 0) ? 16 : 8; endfunction
    function automatic bit p_dw(int d);    return (d == 0); endfunction
    function automatic int p_cmax(int d);  return (d == 0) ? 65535 : 3; endfunction
    function automatic int p_nop(int d);   return (d == 0) ? 4 : 3; endfunction

    // Model state per instance
    bit          m_viol [2];
    logic [31:0] m_vinst [2];
    int          m_vlane [2];
    int          m_acc [2];
    int          m_run [2];
    bit          m_hit [2];

    logic [1:0] last_ok_a;
    logic [2:0] last_ok_b;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Membership of a word in the QED subset, straight from the mnemonic list.
    function automatic bit m_allowed(logic [31:0] w, int rl, bit dw);
        int op, rd, f3, r1, r2, f7;
        op = int'(w[6:0]);   rd = int'(w[11:7]);  f3 = int'(w[14:12]);
        r1 = int'(w[19:15]); r2 = int'(w[24:20]); f7 = int'(w[31:25]);
        if (w == NOP) return 1'b1;
        case (op)
            'h33: return (f7 == 0 || f7 == 1 || (f7 == 32 && (f3 == 0 || f3 == 5)))
                         && rd < rl && r1 < rl && r2 < rl;
            'h3B: return ((f7 == 0 && (f3 == 0 || f3 == 1 || f3 == 5)) ||
                          (f7 == 32 && (f3 == 0 || f3 == 5)) ||
                          (f7 == 1 && (f3 == 0 || f3 >= 4)))
                         && rd < rl && r1 < rl && r2 < rl;
            'h13: return (f3 != 1 && f3 != 5) && rd < rl && r1 < rl;
            'h1B: return f3 == 0 && rd < rl && r1 < rl;
            'h03: return (f3 == 2 || (dw && f3 == 3)) && r1 == 0 && w[31:30] == 2'b00 && rd < rl;
            'h23: return (f3 == 2 || (dw && f3 == 3)) && r1 == 0 && w[31:30] == 2'b00 && r2 < rl;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void m_update(int d, logic r, logic c, logic [2:0] v, logic [95:0] ws);
        logic [31:0] w;
        int n;
        bit idle, bad;
        n = 0; idle = 1'b1; bad = 1'b0;
        if (!r || c) begin
            m_viol[d] = 1'b0; m_vinst[d] = 32'd0; m_vlane[d] = 0;
            m_acc[d] = 0; m_run[d] = 0; m_hit[d] = 1'b0;
        end else begin
            for (int i = 0; i < p_lanes(d); i++) begin
                w = ws[32*i +: 32];
                if (v[i]) begin
                    if (m_allowed(w, p_rl(d), p_dw(d))) n++;
                    else begin
                        if (!bad && !m_viol[d]) begin m_vinst[d] = w; m_vlane[d] = i; end
                        bad = 1'b1;
                    end
                    if (w != NOP) idle = 1'b0;
                end
            end
            if (bad) m_viol[d] = 1'b1;
            m_acc[d] = (m_acc[d] + n > p_cmax(d)) ? p_cmax(d) : m_acc[d] + n;
            if (idle) begin
                m_run[d] = (m_run[d] + 1 > p_nop(d)) ? p_nop(d) : m_run[d] + 1;
                if (m_run[d] == p_nop(d)) m_hit[d] = 1'b1;
            end else begin
                m_run[d] = 0;
            end
        end
    endfunction

    task automatic chk_out(input int d, input logic vi, input logic [31:0] vw,
                           input logic [2:0] vl, input logic [31:0] acc, input logic hit);
        chk($sformatf("m%0d_violation", d), {31'd0, vi}, {31'd0, m_viol[d]});
        chk($sformatf("m%0d_viol_inst", d), vw, m_vinst[d]);
        chk($sformatf("m%0d_viol_lane", d), {29'd0, vl}, 32'(m_vlane[d]));
        chk($sformatf("m%0d_acc_cnt", d), acc, 32'(m_acc[d]));
        chk($sformatf("m%0d_nop_run_hit", d), {31'd0, hit}, {31'd0, m_hit[d]});
    endtask

    // One clock: apply inputs, check lane_ok combinationally, clock, check registered state.
    task automatic step(input logic r, input logic c, input logic [2:0] v,
                        input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        logic [95:0] ws;
        logic [2:0]  exp_ok;
        ws = {w2, w1, w0};
        rst_n = r; clear = c;
        bus_a.inst_valid = v[1:0]; bus_a.inst = {w1, w0};
        bus_b.inst_valid = v;      bus_b.inst = ws;
        #1;
        last_ok_a = bus_a.lane_ok;
        last_ok_b = bus_b.lane_ok;
        for (int d = 0; d < 2; d++) begin
            exp_ok = 3'b000;
            for (int i = 0; i < p_lanes(d); i++)
                exp_ok[i] = v[i] && m_allowed(ws[32*i +: 32], p_rl(d), p_dw(d));
            chk($sformatf("m%0d_lane_ok", d), (d == 0) ? {30'd0, last_ok_a} : {29'd0, last_ok_b},
                {29'd0, exp_ok});
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) m_update(d, r, c, v, ws);
        chk_out(0, viol_a, vinst_a, vlane_a, {16'd0, acc_a}, hit_a);
        chk_out(1, viol_b, vinst_b, vlane_b, {30'd0, acc_b}, hit_b);
    endtask

    function automatic logic [4:0] rreg();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    endfunction

    function automatic logic [31:0] rnd_word();
        logic [6:0] f7;
        logic [2:0] f3;
        f3 = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
            0: f7 = 7'd0;
            1: f7 = 7'd1;
            2: f7 = 7'd32;
            default: f7 = 7'($urandom_range(0, 127));
        endcase
        case ($urandom_range(0, 7))
            0: return {f7, rreg(), rreg(), f3, rreg(), 7'b0110011};
            1: return {f7, rreg(), rreg(), f3, rreg(), 7'b0111011};
            2: return {12'($urandom), rreg(), f3, rreg(), 7'b0010011};
            3: return {12'($urandom), rreg(), f3, rreg(), 7'b0011011};
            4: return {($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00, 10'($urandom),
                       ($urandom_range(0, 2) == 0) ? rreg() : 5'd0,
                       ($urandom_range(0, 2) == 0) ? f3 : 3'($urandom_range(2, 3)),
                       rreg(), 7'b0000011};
            5: return {($urandom_range(0, 3) == 0) ? 2'b01 : 2'b00, 5'($urandom), rreg(),
                       ($urandom_range(0, 2) == 0) ? rreg() : 5'd0,
                       ($urandom_range(0, 2) == 0) ? f3 : 3'($urandom_range(2, 3)),
                       5'($urandom), 7'b0100011};
            6: return NOP;
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [1:0]  v;
        logic [31:0] i0;
        logic [31:0] i1;
        logic [1:0]  exp;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{2'b11, ADD,          NOP,          2'b11};
        tbl[1] = '{2'b11, SLLI,         ADD,          2'b10};
        tbl[2] = '{2'b01, 32'h00012083, ADD20,        2'b00};
        tbl[3] = '{2'b11, 32'h00002083, 32'h00003083, 2'b11};
        tbl[4] = '{2'b11, 32'h00102023, 32'h00103023, 2'b11};
        tbl[5] = '{2'b11, 32'h023100B3, 32'h403100B3, 2'b11};
        tbl[6] = '{2'b11, 32'h403120B3, 32'h0051009B, 2'b10};
        tbl[7] = '{2'b11, 32'h023150BB, 32'h023110BB, 2'b01};
        tbl[8] = '{2'b11, 32'h80002083, 32'hFFF24193, 2'b10};
        tbl[9] = '{2'b11, 32'h00F780B3, 32'h00310833, 2'b01};

        rst_n = 1'b0; clear = 1'b0;
        bus_a.inst_valid = '0; bus_a.inst = '0;
        bus_b.inst_valid = '0; bus_b.inst = '0;

        // Reset state
        step(1'b0, 1'b0, 3'b011, SLLI, SLLI, NOP);
        step(1'b0, 1'b0, 3'b000, NOP, NOP, NOP);
        chk("rst_violation", {31'd0, viol_a}, 32'd0);
        chk("rst_acc", {16'd0, acc_a}, 32'd0);
        chk("rst_hit", {31'd0, hit_a}, 32'd0);

        // Scenario 1: ADD + NOP
        step(1'b1, 1'b0, 3'b011, ADD, NOP, NOP);
        chk("s1_lane_ok", {30'd0, last_ok_a}, 32'd3);
        chk("s1_acc", {16'd0, acc_a}, 32'd2);
        chk("s1_violation", {31'd0, viol_a}, 32'd0);

        // Scenario 2: first offender on lane 1, later offender ignored
        step(1'b1, 1'b0, 3'b011, ADD, ADD20, NOP);
        chk("s2_violation", {31'd0, viol_a}, 32'd1);
        chk("s2_viol_lane", {29'd0, vlane_a}, 32'd1);
        chk("s2_viol_inst", vinst_a, 32'h00108A33);
        step(1'b1, 1'b0, 3'b001, SLLI, NOP, NOP);
        chk("s2_keep_inst", vinst_a, 32'h00108A33);
        chk("s2_keep_lane", {29'd0, vlane_a}, 32'd1);

        // Scenario 3: load addressing and doubleword acceptance
        step(1'b1, 1'b1, 3'b000, NOP, NOP, NOP);
        chk("s3_clear_viol", {31'd0, viol_a}, 32'd0);
        step(1'b1, 1'b0, 3'b001, 32'h00012083, NOP, NOP);
        chk("s3_lw_rs1", {31'd0, viol_a}, 32'd1);
        chk("s3_lw_lane", {29'd0, vlane_a}, 32'd0);
        step(1'b1, 1'b0, 3'b001, 32'h00002083, NOP, NOP);
        chk("s3_lw_ok", {30'd0, last_ok_a}, 32'd1);
        step(1'b1, 1'b0, 3'b001, 32'h00003083, NOP, NOP);
        chk("s3_ld_dw1", {30'd0, last_ok_a}, 32'd1);
        chk("s3_ld_dw0", {29'd0, last_ok_b}, 32'd0);

        // Scenario 4: idle watchdog with limit 4
        step(1'b1, 1'b1, 3'b000, NOP, NOP, NOP);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 3'b000, ADD, ADD, ADD);
        chk("s4_hit_early", {31'd0, hit_a}, 32'd0);
        step(1'b1, 1'b0, 3'b011, NOP, NOP, NOP);
        chk("s4_hit", {31'd0, hit_a}, 32'd1);
        step(1'b1, 1'b1, 3'b000, NOP, NOP, NOP);
        step(1'b1, 1'b0, 3'b000, NOP, NOP, NOP);
        step(1'b1, 1'b0, 3'b011, NOP, NOP, NOP);
        step(1'b1, 1'b0, 3'b001, ADD, NOP, NOP);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 3'b010, ADD, NOP, NOP);
        chk("s4_restart", {31'd0, hit_a}, 32'd0);

        // Scenario 5: 2-bit counter saturates
        step(1'b1, 1'b1, 3'b000, NOP, NOP, NOP);
        step(1'b1, 1'b0, 3'b011, ADD, ADD, NOP);
        chk("s5_acc1", {30'd0, acc_b}, 32'd2);
        step(1'b1, 1'b0, 3'b011, ADD, ADD, NOP);
        chk("s5_acc2", {30'd0, acc_b}, 32'd3);
        step(1'b1, 1'b0, 3'b011, ADD, ADD, NOP);
        chk("s5_acc3", {30'd0, acc_b}, 32'd3);

        // Scenario 6: clear beats same-cycle offender, then reset mid-run
        step(1'b1, 1'b0, 3'b001, SLLI, NOP, NOP);
        chk("s6_viol", {31'd0, viol_a}, 32'd1);
        step(1'b1, 1'b1, 3'b011, SLLI, ADD, NOP);
        chk("s6_clear_viol", {31'd0, viol_a}, 32'd0);
        chk("s6_clear_acc", {16'd0, acc_a}, 32'd0);
        step(1'b1, 1'b0, 3'b010, NOP, SLLI, NOP);
        step(1'b0, 1'b0, 3'b011, ADD, ADD, NOP);
        chk("s6_rst_viol", {31'd0, viol_a}, 32'd0);
        chk("s6_rst_inst", vinst_a, 32'd0);
        chk("s6_rst_lane", {29'd0, vlane_a}, 32'd0);
        chk("s6_rst_acc", {16'd0, acc_a}, 32'd0);
        chk("s6_rst_hit", {31'd0, hit_a}, 32'd0);

        // Decode table
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b0, {1'b0, tbl[k].v}, tbl[k].i0, tbl[k].i1, NOP);
            chk($sformatf("tbl%0d_lane_ok", k), {30'd0, last_ok_a}, {30'd0, tbl[k].exp});
        end

        // Randomized run against the model
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0)
                step($urandom_range(0, 99) != 0, $urandom_range(0, 49) == 0,
                     3'($urandom_range(0, 7)), NOP, NOP, NOP);
            else
                step($urandom_range(0, 99) != 0, $urandom_range(0, 49) == 0,
                     3'($urandom_range(0, 7)), rnd_word(), rnd_word(), rnd_word());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
